// File: rtl/dsp_mul_arb.sv
// dsp_mul_arb: shares one 2-stage dsp_mul multiply-accumulate block between
// NREQ requesters. Grants at most one request per cycle, tracks the requester
// ID of each operation through the multiplier pipeline and returns results on
// one tagged response channel with backpressure.
//
// Arbitration: define DSP_MUL_ARB_RR_EN for round-robin; left undefined, the
// arbiter is fixed priority (lowest asserted index wins) and has no pointer.
//
// Ports:
//   clock0, aclr0          clock, asynchronous active-high reset
//   req_valid/req_ready    per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b           NREQ x 32-bit operands, requester i at [32i+31:32i]
//   req_signa, req_signb   per-requester operand signedness
//   req_acc                NREQ x 64-bit accumulate addend (to chainin)
//   rsp_valid/rsp_ready    result handshake
//   rsp_id, rsp_result     requester index and acc + a*b (mod 2^64)
//   mul_*                  operand/sign/chainin/enable to dsp_mul, result back
//   busy                   any operation in flight
module dsp_mul_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic                 clock0,
   input  logic                 aclr0,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*32-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   input  logic [NREQ-1:0]      req_signa,
   input  logic [NREQ-1:0]      req_signb,
   input  logic [NREQ*64-1:0]   req_acc,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [63:0]          rsp_result,
   output logic [31:0]          mul_dataa,
   output logic [31:0]          mul_datab,
   output logic                 mul_signa,
   output logic                 mul_signb,
   output logic [63:0]          mul_chainin,
   output logic                 mul_ena,
   input  logic [63:0]          mul_result,
   output logic                 busy
);

   // Pipeline tracking: s1 mirrors the multiplier input registers,
   // s2 mirrors dsp_mul.result.
   logic           s1_valid;
   logic [IDW-1:0] s1_id;
   logic           s2_valid;
   logic [IDW-1:0] s2_id;

   logic           any_valid;
   logic [IDW-1:0] grant;
   logic           fire;

`ifdef DSP_MUL_ARB_RR_EN
   logic [IDW-1:0] ptr;

   // Round-robin search starting at ptr, wrapping modulo NREQ.
   always_comb begin
      int unsigned idx;
      any_valid = 1'b0;
      grant     = '0;
      idx       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any_valid && req_valid[idx]) begin
            any_valid = 1'b1;
            grant     = IDW'(idx);
         end
      end
   end

   // Pointer moves past the winner only when a request actually fires.
   always_ff @(posedge clock0 or posedge aclr0) begin
      if (aclr0) begin
         ptr <= '0;
      end else if (fire) begin
         ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
      end
   end
`else
   // Fixed priority: scanning downward leaves the lowest asserted index.
   always_comb begin
      any_valid = 1'b0;
      grant     = '0;
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            any_valid = 1'b1;
            grant     = IDW'(k);
         end
      end
   end
`endif

   // Pipeline advances unless a presented result is being held back.
   assign mul_ena = !s2_valid | rsp_ready;

   // Grant is suppressed during reset so nothing fires while aclr0 is high.
   always_comb begin
      req_ready = '0;
      if (any_valid && mul_ena && !aclr0) req_ready[grant] = 1'b1;
   end

   assign fire = |(req_valid & req_ready);

   // Operand mux; grant defaults to 0 when idle, chainin is zeroed then.
   assign mul_dataa   = req_a[grant*32 +: 32];
   assign mul_datab   = req_b[grant*32 +: 32];
   assign mul_signa   = req_signa[grant];
   assign mul_signb   = req_signb[grant];
   assign mul_chainin = any_valid ? req_acc[grant*64 +: 64] : 64'd0;

   // ID/valid tracking in lockstep with the multiplier's ena0-gated stages.
   always_ff @(posedge clock0 or posedge aclr0) begin
      if (aclr0) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s2_valid <= 1'b0;
         s2_id    <= '0;
      end else if (mul_ena) begin
         s1_valid <= fire;
         s1_id    <= grant;
         s2_valid <= s1_valid;
         s2_id    <= s1_id;
      end
   end

   assign rsp_valid  = s2_valid;
   assign rsp_id     = s2_id;
   assign rsp_result = mul_result;
   assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_dsp_mul_arb.sv
// tb_dsp_mul_arb: self-checking bench for dsp_mul_arb with a behavioural
// dsp_mul stand-in and an in-order response scoreboard.
module tb_dsp_mul_arb;
   localparam int unsigned NREQ = 4;
   localparam int unsigned IDW  = 2;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sa;
      logic        sb;
      logic [63:0] acc;
   } op_t;

   typedef struct {
      logic [IDW-1:0] id;
      logic [63:0]    res;
      int             age;
   } infl_t;

   logic                clock0;
   logic                aclr0;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*32-1:0]  req_a;
   logic [NREQ*32-1:0]  req_b;
   logic [NREQ-1:0]     req_signa;
   logic [NREQ-1:0]     req_signb;
   logic [NREQ*64-1:0]  req_acc;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [IDW-1:0]      rsp_id;
   logic [63:0]         rsp_result;
   logic [31:0]         mul_dataa;
   logic [31:0]         mul_datab;
   logic                mul_signa;
   logic                mul_signb;
   logic [63:0]         mul_chainin;
   logic                mul_ena;
   logic [63:0]         mul_result;
   logic                busy;

   int checks;
   int errors;

   op_t   pend[NREQ][$];
   infl_t q[$];
`ifdef DSP_MUL_ARB_RR_EN
   int    ptr;
`endif

   dsp_mul_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clock0      (clock0),
      .aclr0       (aclr0),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_signa   (req_signa),
      .req_signb   (req_signb),
      .req_acc     (req_acc),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_id      (rsp_id),
      .rsp_result  (rsp_result),
      .mul_dataa   (mul_dataa),
      .mul_datab   (mul_datab),
      .mul_signa   (mul_signa),
      .mul_signb   (mul_signb),
      .mul_chainin (mul_chainin),
      .mul_ena     (mul_ena),
      .mul_result  (mul_result),
      .busy        (busy)
   );

   initial clock0 = 1'b0;
   always #5 clock0 = ~clock0;

   // acc + ext(a)*ext(b), wrapping at 64 bits.
   function automatic logic [63:0] mac(input logic [31:0] a, input logic [31:0] b,
                                       input logic sa, input logic sb,
                                       input logic [63:0] acc);
      logic [63:0] ea;
      logic [63:0] eb;
      ea = sa ? {{32{a[31]}}, a} : {32'd0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'd0, b};
      return ea * eb + acc;
   endfunction

   // Behavioural dsp_mul: input register stage then result register, both ena0-gated.
   logic [31:0] m_a, m_b;
   logic        m_sa, m_sb;
   logic [63:0] m_ci, m_res;
   always_ff @(posedge clock0 or posedge aclr0) begin
      if (aclr0) begin
         m_a <= '0; m_b <= '0; m_sa <= 1'b0; m_sb <= 1'b0; m_ci <= '0; m_res <= '0;
      end else if (mul_ena) begin
         m_res <= mac(m_a, m_b, m_sa, m_sb, m_ci);
         m_a   <= mul_dataa;
         m_b   <= mul_datab;
         m_sa  <= mul_signa;
         m_sb  <= mul_signb;
         m_ci  <= mul_chainin;
      end
   end
   assign mul_result = m_res;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic sa, input logic sb, input logic [63:0] acc);
      op_t o;
      o.a = a; o.b = b; o.sa = sa; o.sb = sb; o.acc = acc;
      return o;
   endfunction

   function automatic op_t rand_op();
      return mk_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), {$urandom, $urandom});
   endfunction

   // Present the head of each requester's pending queue.
   task automatic drive();
      for (int i = 0; i < int'(NREQ); i++) begin
         op_t o;
         o = mk_op('0, '0, 1'b0, 1'b0, '0);
         if (pend[i].size() > 0) o = pend[i][0];
         req_valid[i]         = pend[i].size() > 0;
         req_a[32*i +: 32]    = o.a;
         req_b[32*i +: 32]    = o.b;
         req_signa[i]         = o.sa;
         req_signb[i]         = o.sb;
         req_acc[64*i +: 64]  = o.acc;
      end
   endtask

   // One clock cycle: drive, check against the model, clock, update the model.
   task automatic step();
      logic            exp_rv;
      logic            exp_ena;
      logic            found;
      logic [IDW-1:0]  g;
      logic [NREQ-1:0] exp_rdy;
      int              idx;
      op_t             o;
      infl_t           n;
      drive();
      #1;
      exp_rv = (q.size() > 0) && (q[0].age == 2);
      chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
      if (exp_rv) begin
         chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
         chk("rsp_result", rsp_result, q[0].res);
      end
      chk("busy", 64'(busy), 64'(q.size() > 0));
      exp_ena = !exp_rv || rsp_ready;
      chk("mul_ena", 64'(mul_ena), 64'(exp_ena));
      found = 1'b0;
      g     = '0;
      for (int k = 0; k < int'(NREQ); k++) begin
`ifdef DSP_MUL_ARB_RR_EN
         idx = (ptr + k) % int'(NREQ);
`else
         idx = k;
`endif
         if (!found && pend[idx].size() > 0) begin
            found = 1'b1;
            g     = IDW'(idx);
         end
      end
      exp_rdy = '0;
      if (found && exp_ena) exp_rdy[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (!found) chk("idle_chainin", mul_chainin, 64'd0);
      @(posedge clock0);
      if (exp_ena) begin
         if (exp_rv) void'(q.pop_front());
         foreach (q[j]) q[j].age++;
         if (found) begin
            o     = pend[g].pop_front();
            n.id  = g;
            n.res = mac(o.a, o.b, o.sa, o.sb, o.acc);
            n.age = 1;
            q.push_back(n);
`ifdef DSP_MUL_ARB_RR_EN
            ptr = (int'(g) + 1) % int'(NREQ);
`endif
         end
      end
      #1;
   endtask

   function automatic logic all_idle();
      logic idle;
      idle = (q.size() == 0);
      for (int i = 0; i < int'(NREQ); i++) if (pend[i].size() > 0) idle = 1'b0;
      return idle;
   endfunction

   // Run until the model is empty; running out of budget is itself a failure.
   task automatic drain(input int budget);
      int n;
      n = 0;
      while (!all_idle() && n < budget) begin
         step();
         n++;
      end
      chk("drain_done", 64'(all_idle()), 64'd1);
   endtask

   task automatic clear_model();
      q.delete();
      for (int i = 0; i < int'(NREQ); i++) pend[i].delete();
`ifdef DSP_MUL_ARB_RR_EN
      ptr = 0;
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      aclr0     = 1'b1;
      rsp_ready = 1'b1;
      clear_model();
      pend[1].push_back(mk_op(32'd1, 32'd1, 1'b0, 1'b0, 64'd0));
      drive();
      #2;
      // Reset state: outputs inactive even with a request pending.
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_rsp_id", 64'(rsp_id), 64'd0);
      clear_model();
      @(posedge clock0);
      #1 aclr0 = 1'b0;

      // Single op, signed: -1*2 + 10 = 8.
      pend[0].push_back(mk_op(32'hFFFF_FFFF, 32'd2, 1'b1, 1'b1, 64'd10));
      step();
      step();
      chk("single_s_valid", 64'(rsp_valid), 64'd1);
      chk("single_s_id", 64'(rsp_id), 64'd0);
      chk("single_s_result", rsp_result, 64'd8);
      step();

      // Same operands unsigned.
      pend[0].push_back(mk_op(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 64'd10));
      step();
      step();
      chk("single_u_valid", 64'(rsp_valid), 64'd1);
      chk("single_u_result", rsp_result, 64'h2_0000_0008);
      drain(10);

      // Back-to-back squares from requester 1.
      for (int k = 1; k <= 5; k++)
         pend[1].push_back(mk_op(32'(k), 32'(k), 1'b0, 1'b0, 64'd0));
      step();
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("b2b_valid", 64'(rsp_valid), 64'd1);
         chk("b2b_id", 64'(rsp_id), 64'd1);
         chk("b2b_result", rsp_result, 64'(k * k));
      end
      drain(10);

      // Contention: every requester kept valid.
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < int'(NREQ); i++)
            if (pend[i].size() == 0) pend[i].push_back(rand_op());
         step();
      end
      drain(40);

      // Backpressure: stall with operations in flight.
      for (int k = 0; k < 3; k++) pend[2].push_back(rand_op());
      step();
      step();
      rsp_ready = 1'b0;
      for (int c = 0; c < 4; c++) step();
      rsp_ready = 1'b1;
      drain(10);

      // Bubbles: fire on alternate cycles.
      for (int c = 0; c < 6; c++) begin
         pend[3].push_back(rand_op());
         step();
         step();
      end
      drain(10);

      // Randomised traffic with random backpressure.
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < int'(NREQ); i++)
            if (pend[i].size() == 0 && $urandom_range(0, 2) != 0) pend[i].push_back(rand_op());
         rsp_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      rsp_ready = 1'b1;
      drain(60);

      // Reset with two operations in flight.
      pend[1].push_back(rand_op());
      pend[3].push_back(rand_op());
      step();
      step();
      pend[2].push_back(rand_op());
      drive();
      #2 aclr0 = 1'b1;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      clear_model();
      @(posedge clock0);
      #1 aclr0 = 1'b0;
      for (int i = 0; i < int'(NREQ); i++) pend[i].push_back(rand_op());
      drive();
      #1;
      chk("postrst_grant", 64'(req_ready), 64'd1);
      for (int c = 0; c < 8; c++) step();
      drain(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
